// File: rtl/auth_sequencer.sv
// auth_sequencer: OTP capture, user entry, compare, retry/lockout control and display scan
module auth_sequencer #(
  parameter int DATA_W        = 4,
  parameter int N_DIGITS      = 2,
  parameter int MAX_TRIES     = 3,
  parameter int HOLD_CYCLES   = 4,
  parameter int LOCK_CYCLES   = 16,
  parameter int ENTRY_TIMEOUT = 64,
  parameter int SCAN_CYCLES   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               otp_word,
  input  logic                            otp_latch,
  input  logic                            user_latch,
  input  logic [DATA_W-1:0]               user_in,
  output logic [DATA_W-1:0]               otp_disp,
  output logic [DATA_W-1:0]               user_disp,
  output logic [$clog2(N_DIGITS)-1:0]     scan_idx,
  output logic [$clog2(N_DIGITS+1)-1:0]   digit_idx,
  output logic [3:0]                      tries_left,
  output logic                            granted,
  output logic                            denied,
  output logic                            locked,
  output logic [2:0]                      state
);
  localparam int SW   = $clog2(N_DIGITS);
  localparam int DW   = $clog2(N_DIGITS + 1);
  localparam int TM1  = HOLD_CYCLES > LOCK_CYCLES ? HOLD_CYCLES : LOCK_CYCLES;
  localparam int TMAX = TM1 > ENTRY_TIMEOUT ? TM1 : ENTRY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(SCAN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, ENTRY, CHECK, GRANT, FAIL, LOCK} state_t;
  state_t st, st_n;
  logic [2:0] otp_sync, user_sync;
  logic otp_evt, user_evt;
  logic [N_DIGITS-1:0][DATA_W-1:0] otp_reg, entry_reg;
  logic [SW-1:0] cap_cnt;
  logic [TW-1:0] tmr;
  logic [CW-1:0] scan_cnt;
  logic match, last_digit, hold_done, lock_done, timed_out, scan_wrap;
  assign state      = st;
  assign match      = otp_reg == entry_reg;
  assign last_digit = user_evt && digit_idx == DW'(N_DIGITS - 1);
  assign hold_done  = tmr == TW'(HOLD_CYCLES - 1);
  assign lock_done  = tmr == TW'(LOCK_CYCLES - 1);
  assign timed_out  = !user_evt && tmr == TW'(ENTRY_TIMEOUT - 1);
  assign scan_wrap  = scan_cnt == CW'(SCAN_CYCLES - 1);
  always_comb begin
    st_n = IDLE;
    case (st)
      IDLE:    st_n = otp_evt ? CAPTURE : IDLE;
      CAPTURE: st_n = cap_cnt == SW'(N_DIGITS - 1) ? ENTRY : CAPTURE;
      ENTRY:   st_n = last_digit ? CHECK : timed_out ? IDLE : ENTRY;
      CHECK:   st_n = match ? GRANT : tries_left <= 4'd1 ? LOCK : FAIL;
      GRANT:   st_n = hold_done ? IDLE : GRANT;
      FAIL:    st_n = hold_done ? ENTRY : FAIL;
      LOCK:    st_n = lock_done ? IDLE : LOCK;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) st <= !reset ? IDLE : st_n;
  always_ff @(posedge clk) begin
    if (!reset) begin
      otp_sync   <= '0;
      user_sync  <= '0;
      otp_evt    <= 1'b0;
      user_evt   <= 1'b0;
      otp_reg    <= '0;
      entry_reg  <= '0;
      cap_cnt    <= '0;
      digit_idx  <= '0;
      tmr        <= '0;
      tries_left <= 4'(MAX_TRIES);
      user_disp  <= '0;
      otp_disp   <= '0;
      scan_cnt   <= '0;
      scan_idx   <= '0;
      granted    <= 1'b0;
      denied     <= 1'b0;
      locked     <= 1'b0;
    end else begin
      otp_sync  <= {otp_sync[1:0], otp_latch};
      user_sync <= {user_sync[1:0], user_latch};
      otp_evt   <= otp_sync[1] & ~otp_sync[2];
      user_evt  <= user_sync[1] & ~user_sync[2];
      tmr       <= (st_n != st || (st == ENTRY && user_evt)) ? '0 : tmr + 1'b1;
      scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap) scan_idx <= scan_idx == SW'(N_DIGITS - 1) ? '0 : scan_idx + 1'b1;
      otp_disp  <= otp_reg[scan_idx];
      granted   <= st_n == GRANT;
      denied    <= st_n == FAIL;
      locked    <= st_n == LOCK;
      if (st == CAPTURE) begin
        otp_reg[cap_cnt] <= otp_word;
        cap_cnt          <= cap_cnt + 1'b1;
      end else cap_cnt <= '0;
      if (st_n == ENTRY && st != ENTRY) digit_idx <= '0;
      else if (st == ENTRY && user_evt) begin
        entry_reg[digit_idx[SW-1:0]] <= user_in;
        user_disp                    <= user_in;
        digit_idx                    <= digit_idx + 1'b1;
      end
      if (st == CHECK && !match && tries_left != 4'd0) tries_left <= tries_left - 4'd1;
      if (st_n == IDLE && (st == GRANT || st == LOCK || st == ENTRY)) otp_reg <= '0;
      if (st_n == IDLE && (st == GRANT || st == LOCK)) tries_left <= 4'(MAX_TRIES);
    end
  end
endmodule

// File: tb/tb_auth_sequencer.sv
// tb_auth_sequencer: table-driven vectors with an outcome scoreboard plus multi-cycle corner sequences
module tb_auth_sequencer;
  logic clk = 1'b0, reset = 1'b0, otp_latch = 1'b0, user_latch = 1'b0;
  logic [3:0] otp_word = 4'hF, user_in = 4'h0;
  logic [3:0] otp_disp, user_disp, tries_left;
  logic scan_idx;
  logic [1:0] digit_idx;
  logic granted, denied, locked;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0, cyc = 0, last_wait = 0, run = 0;
  logic [2:0] prev_ind = 3'b000;
  logic [3:0] otp_m [2];
  typedef struct { int kind; int tries; } exp_t;
  typedef struct { bit cap; logic [3:0] o0, o1, d0, d1; int kind; int tries; } vec_t;
  exp_t sb[$];
  exp_t cur;
  vec_t vecs[7];
  auth_sequencer dut (
    .clk(clk), .reset(reset), .otp_word(otp_word), .otp_latch(otp_latch),
    .user_latch(user_latch), .user_in(user_in), .otp_disp(otp_disp), .user_disp(user_disp),
    .scan_idx(scan_idx), .digit_idx(digit_idx), .tries_left(tries_left),
    .granted(granted), .denied(denied), .locked(locked), .state(state)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic monitor();
    logic [2:0] ind;
    ind = {locked, denied, granted};
    if (ind != 3'b000 && prev_ind == 3'b000) begin
      if (sb.size() == 0) begin
        cur.kind = int'(ind);
        check("unexpected_indication", 32'(ind), 0);
      end else begin
        cur = sb.pop_front();
        check("indication_kind", 32'(ind), cur.kind);
        check("tries_at_result", 32'(tries_left), cur.tries);
      end
      run = 0;
    end
    if (ind != 3'b000) run++;
    if (ind == 3'b000 && prev_ind != 3'b000) check("indication_cycles", run, cur.kind == 4 ? 16 : 4);
    prev_ind = ind;
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      monitor();
    end
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget);
    last_wait = 0;
    while (state !== s && last_wait < budget) begin
      tick();
      last_wait++;
    end
    check("wait_state", 32'(state), 32'(s));
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cyc = 0;
  endtask
  task automatic capture(input logic [3:0] o0, input logic [3:0] o1);
    otp_latch = 1'b1;
    wait_state(3'd1, 10);
    otp_latch = 1'b0;
    otp_word = o0;
    tick();
    otp_word = o1;
    tick();
    otp_word = 4'hF;
    otp_m[0] = o0;
    otp_m[1] = o1;
    check("capture_to_entry", 32'(state), 2);
  endtask
  task automatic enter_digit(input logic [3:0] v);
    user_in = v;
    user_latch = 1'b1;
    tick(2);
    user_latch = 1'b0;
    tick(2);
  endtask
  task automatic enter_code(input logic [3:0] d0, input logic [3:0] d1, input int kind, input int tries);
    sb.push_back('{kind, tries});
    enter_digit(d0);
    check("digit_idx_one", 32'(digit_idx), 1);
    enter_digit(d1);
    check("check_state", 32'(state), 3);
    check("user_disp", 32'(user_disp), 32'(d1));
  endtask
  task automatic check_reset_outputs(input string nm);
    check({nm, "_state"}, 32'(state), 0);
    check({nm, "_tries"}, 32'(tries_left), 3);
    check({nm, "_digit_idx"}, 32'(digit_idx), 0);
    check({nm, "_scan_idx"}, 32'(scan_idx), 0);
    check({nm, "_otp_disp"}, 32'(otp_disp), 0);
    check({nm, "_user_disp"}, 32'(user_disp), 0);
    check({nm, "_gdl"}, 32'({granted, denied, locked}), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{1'b0, 4'h0, 4'h0, 4'h3, 4'h9, 1, 3};
    vecs[1] = '{1'b1, 4'h3, 4'h9, 4'h3, 4'h5, 2, 2};
    vecs[2] = '{1'b0, 4'h0, 4'h0, 4'h3, 4'h9, 1, 2};
    vecs[3] = '{1'b1, 4'h7, 4'h1, 4'h1, 4'h7, 2, 2};
    vecs[4] = '{1'b0, 4'h0, 4'h0, 4'h7, 4'h0, 2, 1};
    vecs[5] = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4, 0};
    vecs[6] = '{1'b1, 4'hA, 4'hC, 4'hA, 4'hC, 1, 3};
    do_reset();
    check_reset_outputs("reset");
    capture(4'h3, 4'h9);
    check("otp_event_latency", last_wait, 4);
    tick();
    for (int i = 0; i < 12; i++) begin
      check("scan_idx", 32'(scan_idx), (cyc / 4) % 2);
      check("otp_disp_scan", 32'(otp_disp), 32'(otp_m[((cyc - 1) / 4) % 2]));
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].cap) capture(vecs[i].o0, vecs[i].o1);
      enter_code(vecs[i].d0, vecs[i].d1, vecs[i].kind, vecs[i].tries);
      if (vecs[i].kind == 2) begin
        wait_state(3'd2, 20);
        check("digit_idx_after_fail", 32'(digit_idx), 0);
      end else if (vecs[i].kind == 4) begin
        tick(2);
        otp_latch = 1'b1;
        tick(3);
        otp_latch = 1'b0;
        wait_state(3'd0, 30);
        tick(8);
        check("lock_otp_press_ignored", 32'(state), 0);
        check("lock_tries_reload", 32'(tries_left), 3);
        check("lock_otp_cleared", 32'(otp_disp), 0);
      end else begin
        wait_state(3'd0, 20);
        tick();
        check("grant_otp_cleared", 32'(otp_disp), 0);
        check("grant_tries_reload", 32'(tries_left), 3);
      end
    end
    capture(4'h5, 4'h6);
    enter_digit(4'h5);
    check("timeout_digit_idx", 32'(digit_idx), 1);
    wait_state(3'd0, 100);
    check("timeout_cycles", last_wait, 64);
    tick(2);
    check("timeout_otp_cleared", 32'(otp_disp), 0);
    check("timeout_tries_kept", 32'(tries_left), 3);
    capture(4'h1, 4'h2);
    user_in = 4'h1;
    user_latch = 1'b1;
    tick(20);
    check("hold_one_digit", 32'(digit_idx), 1);
    check("hold_state_entry", 32'(state), 2);
    user_latch = 1'b0;
    tick(3);
    check("hold_release_no_digit", 32'(digit_idx), 1);
    check("hold_user_disp", 32'(user_disp), 1);
    reset = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("otp_discarded", 32'(otp_disp), 0);
    end
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/auth_sequencer.md
Name: auth_sequencer

Overview:
- Control FSM for the one-time-password authentication datapath.
- Captures an N-digit OTP from the free-running LFSR word and sequences per-digit user entry from the push-button latch.
- Compares the entry with the OTP, grants or denies, counts failed attempts and enforces a lockout window.
- Drives the digit values and selects for the 7-segment display path. Sits between the pad-level wrapper and the LFSR/7-seg decoders.

Parameters:
- DATA_W, 4, width of one OTP/user digit
- N_DIGITS, 2, digits per OTP (2..8)
- MAX_TRIES, 3, failed attempts allowed before lockout (1..15)
- HOLD_CYCLES, 4, cycles GRANT/FAIL indication is held
- LOCK_CYCLES, 16, lockout duration in cycles
- ENTRY_TIMEOUT, 64, idle cycles in ENTRY before the OTP expires
- SCAN_CYCLES, 4, cycles per display digit in the scan

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- otp_word  in  DATA_W  current LFSR output, advances every cycle
- otp_latch  in  1  async button: request new OTP
- user_latch  in  1  async button: commit user_in as next digit
- user_in  in  DATA_W  user digit value, sampled on a user_latch event
- otp_disp  out  DATA_W  OTP digit selected by scan_idx
- user_disp  out  DATA_W  last committed user digit
- scan_idx  out  $clog2(N_DIGITS)  display digit select (anode drive)
- digit_idx  out  $clog2(N_DIGITS+1)  number of digits entered so far
- tries_left  out  4  remaining attempts
- granted  out  1  access granted indication
- denied  out  1  wrong code indication
- locked  out  1  lockout active
- state  out  3  FSM state code, for debug

Behaviour:
- Reset: all registers clear on a clk edge with reset=0.
  - state=IDLE, tries_left=MAX_TRIES. All OTP and entry registers are 0.
  - digit_idx, scan_idx, all timers, granted, denied and locked are 0.
  - Synchronisers clear. A reset mid-operation aborts any state and discards the OTP.
- Button inputs:
  - Each button passes through a 2-FF synchroniser, then rising-edge detection.
  - A one-cycle event pulse fires at the 3rd clk edge after the input is first sampled high.
  - The state action takes effect on the next edge.
  - Holding a button high produces one event only.
- State codes: IDLE=0, CAPTURE=1, ENTRY=2, CHECK=3, GRANT=4, FAIL=5, LOCK=6. Codes 7 and up are illegal and force IDLE.
- IDLE: otp_latch event -> CAPTURE with cap_cnt=0. user_latch events are ignored.
- CAPTURE: lasts exactly N_DIGITS cycles.
  - Each cycle does otp_reg[cap_cnt] <= otp_word; cap_cnt++.
  - After the last digit: go to ENTRY, digit_idx=0, timeout counter=0.
- ENTRY:
  - On a user_latch event: entry_reg[digit_idx] <= user_in, user_disp <= user_in, digit_idx++, timeout counter cleared.
  - When the committed digit is the N_DIGITS-th: go to CHECK.
  - With no event for ENTRY_TIMEOUT consecutive cycles: go to IDLE, OTP cleared to 0, tries_left unchanged, no denied pulse.
  - otp_latch events are ignored in every state except IDLE.
- CHECK: one cycle.
  - Full equality of all N_DIGITS digits -> GRANT.
  - Otherwise tries_left-- ; if the result is 0 -> LOCK, else -> FAIL.
- GRANT:
  - granted=1 for exactly HOLD_CYCLES cycles, then IDLE.
  - tries_left reloads to MAX_TRIES and the OTP is cleared (single use).
- FAIL:
  - denied=1 for HOLD_CYCLES cycles, then ENTRY with digit_idx=0 and the same OTP retained.
  - Events arriving during FAIL are dropped.
- LOCK:
  - locked=1 for LOCK_CYCLES cycles, then IDLE; tries_left reloads and the OTP is cleared.
  - All button events are ignored during LOCK.
- Outputs: granted, denied and locked are registered, mutually exclusive, and high only in their own state.
- Display scan:
  - scan_idx increments every SCAN_CYCLES in all states and wraps N_DIGITS-1 -> 0.
  - otp_disp = otp_reg[scan_idx] (registered). The OTP is 0 after reset, expiry, grant or lock.
- Counters:
  - Timers are sized $clog2(max+1).
  - tries_left saturates and never underflows.
  - digit_idx never exceeds N_DIGITS.

Test Plan:
- Reset then otp_latch pulse; otp_word = 0x3 then 0x9 on consecutive cycles -> after 2 CAPTURE cycles, otp_reg = {9,3}, state=ENTRY; otp_disp alternates 3/9 every 4 cycles.
- Correct entry: user_latch with user_in=3, then with user_in=9 -> CHECK -> granted high for exactly 4 cycles, tries_left=3, then IDLE with OTP cleared.
- Wrong entry 3,5 -> denied high for 4 cycles, tries_left=2, return to ENTRY with digit_idx=0; re-entering 3,9 -> granted.
- Three consecutive wrong codes -> the third CHECK goes to LOCK, tries_left=0, locked high for 16 cycles.
  - An otp_latch pulse during LOCK is ignored.
  - IDLE follows with tries_left=3.
- One digit entered, then no activity for 64 cycles -> IDLE, otp_disp=0, tries_left unchanged, denied never asserted.
- Hold user_latch high for 20 cycles during ENTRY -> exactly one digit committed.
  - Pull reset low mid-ENTRY for one edge -> all outputs at reset values on the next cycle.
